// File: rtl/jk_drv_pkg.sv
// Shared types and J/K encodings for the JK bank driver.
package jk_drv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_CLEAR = 2'd2,
        ST_CHECK = 2'd3
    } drv_state_e;

    // {J,K} pairs
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_TOG  = 2'b11;

    // Excitation for one flop moving from q to t.
    function automatic logic [1:0] jk_code(input logic t, input logic q, input logic toggle);
        logic [1:0] c;
        if (t == q) begin
            c = JK_HOLD;
        end else if (toggle) begin
            c = JK_TOG;
        end else if (t) begin
            c = JK_SET;
        end else begin
            c = JK_RST;
        end
        return c;
    endfunction

endpackage

// File: rtl/jk_excitation_enc.sv
// Per-bit J/K excitation from target word and current bank Q.
module jk_excitation_enc
    import jk_drv_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TOGGLE_MODE = 0
) (
    input  logic [WIDTH-1:0] target,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k
);

    localparam logic TOGGLE_C = (TOGGLE_MODE != 0);

    // Encode every bit independently.
    always_comb begin
        j = {WIDTH{1'b0}};
        k = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            {j[i], k[i]} = jk_code(target[i], q[i], TOGGLE_C);
        end
    end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives an external JK flop bank to a requested word, verifies the
// feedback and retries a bounded number of times before flagging err.
module jk_bank_driver
    import jk_drv_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TOGGLE_MODE = 0,
    parameter int MAX_RETRY   = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic             init_req,
    output logic [WIDTH-1:0] jk_j,
    output logic [WIDTH-1:0] jk_k,
    output logic             jk_clear,
    input  logic [WIDTH-1:0] q_fb,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);
    localparam logic [RW-1:0] ONE_C       = RW'(1);

    drv_state_e       state_q, state_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic [WIDTH-1:0] jk_j_q, jk_j_d;
    logic [WIDTH-1:0] jk_k_q, jk_k_d;
    logic             jk_clear_q, jk_clear_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic [RW-1:0]    retry_q, retry_d;

    logic [WIDTH-1:0] enc_tgt_s;
    logic [WIDTH-1:0] enc_j_s;
    logic [WIDTH-1:0] enc_k_s;
    logic             tgt_ready_s;

    // In IDLE the excitation is for the incoming word; otherwise for the latched one.
    assign enc_tgt_s   = (state_q == ST_IDLE) ? tgt_data : tgt_q;
    // reset_n term keeps ready low while the block is held in reset.
    assign tgt_ready_s = (state_q == ST_IDLE) && !init_req && reset_n;

    jk_excitation_enc #(
        .WIDTH       (WIDTH),
        .TOGGLE_MODE (TOGGLE_MODE)
    ) u_enc (
        .target (enc_tgt_s),
        .q      (q_fb),
        .j      (enc_j_s),
        .k      (enc_k_s)
    );

    // Next-state and registered-output logic; J/K and clear default to inactive.
    always_comb begin
        state_d    = state_q;
        tgt_d      = tgt_q;
        jk_j_d     = {WIDTH{1'b0}};
        jk_k_d     = {WIDTH{1'b0}};
        jk_clear_d = 1'b0;
        done_d     = 1'b0;
        err_d      = 1'b0;
        retry_d    = retry_q;
        case (state_q)
            ST_IDLE: begin
                if (init_req) begin
                    state_d    = ST_CLEAR;
                    tgt_d      = {WIDTH{1'b0}};
                    jk_clear_d = 1'b1;
                end else if (tgt_valid && tgt_ready_s) begin
                    state_d = ST_DRIVE;
                    tgt_d   = tgt_data;
                    jk_j_d  = enc_j_s;
                    jk_k_d  = enc_k_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                state_d = ST_CHECK;
            end
            ST_CLEAR: begin
                state_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (q_fb == tgt_q) begin
                    done_d  = 1'b1;
                    retry_d = {RW{1'b0}};
                    state_d = ST_IDLE;
                end else if (retry_q < MAX_RETRY_C) begin
                    retry_d = retry_q + ONE_C;
                    jk_j_d  = enc_j_s;
                    jk_k_d  = enc_k_s;
                    state_d = ST_DRIVE;
                end else begin
                    err_d   = 1'b1;
                    retry_d = {RW{1'b0}};
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                retry_d = {RW{1'b0}};
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            tgt_q      <= {WIDTH{1'b0}};
            jk_j_q     <= {WIDTH{1'b0}};
            jk_k_q     <= {WIDTH{1'b0}};
            jk_clear_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            retry_q    <= {RW{1'b0}};
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            jk_j_q     <= jk_j_d;
            jk_k_q     <= jk_k_d;
            jk_clear_q <= jk_clear_d;
            done_q     <= done_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            retry_q    <= retry_d;
        end
    end

    assign tgt_ready = tgt_ready_s;
    assign jk_j      = jk_j_q;
    assign jk_k      = jk_k_q;
    assign jk_clear  = jk_clear_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: doc/jk_bank_driver.md
Name: jk_bank_driver

Overview:
- Drives a bank of WIDTH external JK flip-flops so that the bank's Q reaches a requested target word.
- Takes a target over a valid/ready handshake and derives per-bit J/K excitation from the bank's fed-back Q. It drives the bank for one cycle, checks the feedback, retries on mismatch, and reports done or err.
- Also offers an init path that pulses the bank's asynchronous clear.
- It is the stimulus side of the JK storage element: it computes J/K, where the flop consumes J/K.

Parameters:
- WIDTH, 8, number of JK flops in the bank.
- TOGGLE_MODE, 0, excitation style: 0 = set/reset encoding, 1 = toggle encoding.
- MAX_RETRY, 2, number of extra DRIVE attempts after the first mismatch before err.

Ports:
- clk  in  1  rising-edge clock shared with the JK bank.
- reset_n  in  1  asynchronous active-low reset.
- tgt_valid  in  1  target word offered.
- tgt_ready  out  1  driver can accept a target or init.
- tgt_data  in  WIDTH  desired bank value.
- init_req  in  1  request to clear the bank to all zeros.
- jk_j  out  WIDTH  J inputs to the bank, registered.
- jk_k  out  WIDTH  K inputs to the bank, registered.
- jk_clear  out  1  asynchronous clear to the bank, registered.
- q_fb  in  WIDTH  bank Q feedback.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse: bank matches target.
- err  out  1  one-cycle pulse: retries exhausted.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State = IDLE; jk_j, jk_k, jk_clear, done, err, busy, retry count all 0; target register 0.
  - tgt_ready is low while reset_n is low.
- tgt_ready = (state == IDLE) && !init_req, combinational.
- States: IDLE, DRIVE, CLEAR, CHECK.
- IDLE:
  - jk_j = jk_k = 0, so the bank holds.
  - init_req has priority. With init_req high, go to CLEAR: target reg <= 0, jk_clear <= 1. Any simultaneous tgt_valid is not accepted.
  - Else on tgt_valid && tgt_ready, latch tgt_data and go to DRIVE. The excitation is computed from tgt_data versus the current q_fb and registered onto jk_j/jk_k at the same edge.
- DRIVE (exactly 1 cycle):
  - jk_j/jk_k hold the excitation; the bank updates at the edge ending this cycle.
  - At that edge: jk_j, jk_k <= 0; go to CHECK.
- CLEAR (exactly 1 cycle):
  - jk_clear is high. At the edge ending this cycle: jk_clear <= 0; go to CHECK.
- CHECK (1 cycle), compares q_fb with the target register:
  - Match: done <= 1, retry count <= 0, go to IDLE. done is high during the first IDLE cycle.
  - Mismatch and retry count < MAX_RETRY: increment retry count, recompute excitation from the current q_fb, register it onto jk_j/jk_k, go to DRIVE.
  - Mismatch and retry count == MAX_RETRY: err <= 1, retry count <= 0, go to IDLE. The bank is left as-is.
- Excitation, per bit, with t = target and q = q_fb:
  - t == q: J=0, K=0.
  - TOGGLE_MODE 0: 0->1 gives J=1, K=0; 1->0 gives J=0, K=1.
  - TOGGLE_MODE 1: any change gives J=1, K=1.
- Latency with no mismatch:
  - Target accepted at edge E.
  - DRIVE is the cycle after E; CHECK follows; done is high 3 cycles after E; tgt_ready returns in that same cycle.
  - Each retry adds 2 cycles.
- Invariants:
  - jk_j/jk_k are nonzero only in DRIVE.
  - jk_clear is high only in CLEAR.
  - done and err are never high together.
  - A target equal to the current q_fb still runs the full DRIVE/CHECK sequence with zero excitation.
- Reset mid-operation: asynchronously forces the reset values. jk_j, jk_k and jk_clear drop immediately and the pending target is discarded.

Decomposition:
- Package jk_drv_pkg:
  - state enum (IDLE, DRIVE, CLEAR, CHECK);
  - localparams for the J/K encodings (HOLD=2'b00, SET=2'b10, RST=2'b01, TOG=2'b11).
- Sub-module jk_excitation_enc: combinational, parameterized by WIDTH and TOGGLE_MODE; inputs target and q; outputs j and k vectors. It is instantiated once, and the FSM registers its outputs.

Test Plan:
1. Ideal bank model, TOGGLE_MODE=0, bank=8'h00, target 8'hA5 -> DRIVE shows jk_j=8'hA5, jk_k=8'h00; done pulses 3 cycles after accept; q_fb=8'hA5.
2. Bank=8'hF0, target 8'h0F, TOGGLE_MODE=1 -> jk_j = jk_k = 8'hFF in DRIVE; done; q_fb=8'h0F.
3. Bank model ignores bit 3 on the first DRIVE, target 8'h08 from 8'h00 -> first CHECK mismatches; second DRIVE shows jk_j=8'h08; done 5 cycles after accept; err stays 0.
4. Bit 0 stuck at 0, target 8'h01, MAX_RETRY=2 -> three DRIVE cycles; err pulses 7 cycles after accept; done stays 0; tgt_ready returns.
5. init_req and tgt_valid both high in IDLE with bank=8'h3C -> tgt_ready low, target not taken; jk_clear high 1 cycle; done; q_fb=8'h00. Then the held tgt_valid is accepted.
6. reset_n low during DRIVE -> jk_j, jk_k, jk_clear, busy go to 0 immediately; after release, tgt_ready=1 and no done or err is generated for the aborted target.
